// File: rtl/feature_map_loader.sv
// -----------------------------------------------------------------------------
// feature_map_loader
//
// Serial-to-parallel input stage for convolution layer 1. Pixels arrive one
// per handshake in channel-major, row, column order and are packed into a
// flat feature-map register (pixel k at bits [k*FEATURE_BITWIDTH +: FEATURE_BITWIDTH],
// channel 0 in the low bits). When a frame completes, data_valid strobes for
// one cycle and the map is then held (stream stalled) until the accumulator
// signals consume_done.
//
// Optional feature (macro FEATURE_LOADER_FRAME_CHECK_EN): s_last framing check
// with a sticky frame_error flag. Without it, framing is by count alone and
// frame_error is tied low.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   s_pixel       incoming pixel
//   s_valid       pixel present
//   s_last        final pixel marker (only used with the framing check)
//   s_ready       loader accepts a pixel this cycle
//   consume_done  accumulator finished with the current map
//   data_valid    one-cycle strobe: feature_map holds a complete frame
//   feature_map   packed frame
//   pixel_count   pixels accepted in the current frame
//   frame_error   sticky framing error flag
//   o_dbg_state   current FSM state (INIT=0, LOAD=1, FIRE=2, WAIT=3)
//
// Handshake: a pixel is transferred on a rising edge where s_valid && s_ready.
// s_ready is a registered function of state only; the source may hold s_valid
// high while s_ready is low, and nothing is consumed until both are high.
// -----------------------------------------------------------------------------
module feature_map_loader #(
    parameter  int FEATURE_BITWIDTH = 8,
    parameter  int IMAGE_WIDTH      = 28,
    parameter  int IMAGE_HEIGHT     = 28,
    parameter  int INPUT_CHANNELS   = 4,
    localparam int TOTAL            = INPUT_CHANNELS * IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int CW               = $clog2(TOTAL)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [FEATURE_BITWIDTH-1:0]       s_pixel,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    input  logic                              consume_done,
    output logic                              data_valid,
    output logic [FEATURE_BITWIDTH*TOTAL-1:0] feature_map,
    output logic [CW-1:0]                     pixel_count,
    output logic                              frame_error,
    output logic [1:0]                        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIRE = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t                              r_state;
    logic                                r_ready;
    logic                                r_data_valid;
    logic [FEATURE_BITWIDTH*TOTAL-1:0]   r_feature_map;
    logic [CW-1:0]                       r_pixel_count;

    logic                                w_accept;
    logic                                w_last_slot;

    // r_ready is only ever high in LOAD, so this is the accept condition.
    assign w_accept    = s_valid && r_ready;
    assign w_last_slot = (r_pixel_count == CW'(TOTAL - 1));

`ifdef FEATURE_LOADER_FRAME_CHECK_EN
    logic r_frame_error;
    assign frame_error = r_frame_error;
`else
    // s_last carries no meaning without the framing check.
    logic w_unused_s_last;
    assign w_unused_s_last = s_last;
    assign frame_error     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_ready       <= 1'b0;
            r_data_valid  <= 1'b0;
            r_feature_map <= '0;
            r_pixel_count <= '0;
`ifdef FEATURE_LOADER_FRAME_CHECK_EN
            r_frame_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_LOAD;
                    r_ready <= 1'b1;
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_feature_map[int'(r_pixel_count) * FEATURE_BITWIDTH +: FEATURE_BITWIDTH] <= s_pixel;
`ifdef FEATURE_LOADER_FRAME_CHECK_EN
                        // Early s_last: drop the partial frame and restart at slot 0.
                        if (s_last && !w_last_slot) begin
                            r_frame_error <= 1'b1;
                            r_pixel_count <= '0;
                        end else
`endif
                        if (w_last_slot) begin
                            r_pixel_count <= '0;
                            r_state       <= ST_FIRE;
                            r_ready       <= 1'b0;
                            r_data_valid  <= 1'b1;
`ifdef FEATURE_LOADER_FRAME_CHECK_EN
                            // Missing s_last is flagged but the frame is still delivered.
                            if (!s_last) begin
                                r_frame_error <= 1'b1;
                            end
`endif
                        end else begin
                            r_pixel_count <= r_pixel_count + 1'b1;
                        end
                    end
                end

                ST_FIRE: begin
                    r_data_valid <= 1'b0;
                    r_state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (consume_done) begin
                        r_state <= ST_LOAD;
                        r_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= ST_INIT;
                    r_ready      <= 1'b0;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign data_valid  = r_data_valid;
    assign feature_map = r_feature_map;
    assign pixel_count = r_pixel_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_feature_map_loader.sv
// -----------------------------------------------------------------------------
// tb_feature_map_loader
//
// Directed bench for feature_map_loader at default parameters (3136 pixels per
// frame). Inputs are driven on the falling edge; outputs are sampled on the
// falling edge. Expected pixels of the current frame are kept in exp_q in
// accept order and compared slot by slot against feature_map.
// -----------------------------------------------------------------------------
module tb_feature_map_loader;

    localparam int FB    = 8;
    localparam int TOTAL = 3136;
    localparam int CW    = 12;
    localparam int MAPW  = FB * TOTAL;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

`ifdef FEATURE_LOADER_FRAME_CHECK_EN
    localparam logic MISS_FE_EXP = 1'b1;
`else
    localparam logic MISS_FE_EXP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic            clk;
    logic            reset_n;
    logic [FB-1:0]   s_pixel;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic            consume_done;
    logic            data_valid;
    logic [MAPW-1:0] feature_map;
    logic [CW-1:0]   pixel_count;
    logic            frame_error;
    logic [1:0]      o_dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    feature_map_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_pixel      (s_pixel),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .consume_done (consume_done),
        .data_valid   (data_valid),
        .feature_map  (feature_map),
        .pixel_count  (pixel_count),
        .frame_error  (frame_error),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [FB-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_bad    = 0;
    int            dv_cnt   = 0;

    always @(negedge clk) begin
        if (reset_n && data_valid) dv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FB-1:0] pix_val(input int k, input int mode);
        case (mode)
            0:       return 8'(k);
            1:       return 8'(k * 7 + 3);
            2:       return 8'(k * 3 + 1);
            default: return 8'(k) ^ 8'h5A;
        endcase
    endfunction

    task automatic check_map(input string tag);
        int            nbad = 0;
        logic [FB-1:0] got;
        for (int i = 0; i < TOTAL; i++) begin
            got = feature_map[i*FB +: FB];
            if (i >= exp_q.size() || got !== exp_q[i]) nbad++;
        end
        check(tag, 32'(nbad), 32'd0);
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n      = 1'b0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        s_pixel      = '0;
        consume_done = 1'b0;
        #1;
        check({tag, "_rst_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_rst_dv"},    32'(data_valid), 32'd0);
        check({tag, "_rst_cnt"},   32'(pixel_count), 32'd0);
        check({tag, "_rst_fe"},    32'(frame_error), 32'd0);
        check({tag, "_rst_map"},   32'(|feature_map), 32'd0);
        check({tag, "_rst_state"}, 32'(o_dbg_state), 32'(S_INIT));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check({tag, "_rel_ready0"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        check({tag, "_rel_ready1"}, 32'(s_ready), 32'd1);
        check({tag, "_rel_state"},  32'(o_dbg_state), 32'(S_LOAD));
        exp_q.delete();
    endtask

    task automatic send_px(input logic [FB-1:0] px, input logic last);
        int guard = 0;
        s_valid = 1'b1;
        s_pixel = px;
        s_last  = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            exp_q.push_back(px);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drive_frame(input int n, input int mode, input int bubble_pct, input int last_idx);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < bubble_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            send_px(pix_val(k, mode), k == last_idx);
            if (k == 499) check("cnt_mid", 32'(pixel_count), 32'd500);
        end
    endtask

    // Called at the falling edge right after the final accept (FIRE cycle).
    task automatic finish_frame(input string tag, input int dv_before);
        check({tag, "_dv"},    32'(data_valid), 32'd1);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_cnt"},   32'(pixel_count), 32'd0);
        check({tag, "_state"}, 32'(o_dbg_state), 32'(S_FIRE));
        check_map({tag, "_map"});
        @(negedge clk);
        check({tag, "_dv_once"},   32'(dv_cnt - dv_before), 32'd1);
        check({tag, "_dv_low"},    32'(data_valid), 32'd0);
        check({tag, "_state_wt"},  32'(o_dbg_state), 32'(S_WAIT));
    endtask

    // Called at a falling edge in WAIT; expects LOAD on the next cycle.
    task automatic release_map(input string tag);
        consume_done = 1'b1;
        @(negedge clk);
        consume_done = 1'b0;
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_state"}, 32'(o_dbg_state), 32'(S_LOAD));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dv0;
        int hits;
        reset_n      = 1'b0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        s_pixel      = '0;
        consume_done = 1'b0;

        do_reset("init");

        // Frame A: continuous, value k mod 256. consume_done during FIRE is ignored.
        dv0 = dv_cnt;
        drive_frame(TOTAL, 0, 0, TOTAL - 1);
        consume_done = 1'b1;
        finish_frame("a", dv0);
        consume_done = 1'b0;
        check("a_fe", 32'(frame_error), 32'd0);

        // Stall: 50 cycles of offered pixels while the map is held.
        hits = 0;
        dv0  = dv_cnt;
        for (int i = 0; i < 50; i++) begin
            s_valid = 1'b1;
            s_pixel = 8'($urandom);
            s_last  = i[0];
            @(negedge clk);
            if (s_ready) hits++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("stall_ready", 32'(hits), 32'd0);
        check("stall_dv",    32'(dv_cnt - dv0), 32'd0);
        check("stall_state", 32'(o_dbg_state), 32'(S_WAIT));
        check_map("stall_map");
        release_map("stall_rel");

        // Frame B: ~30% bubbles, same values; release from WAIT's first cycle.
        dv0 = dv_cnt;
        drive_frame(TOTAL, 0, 30, TOTAL - 1);
        finish_frame("b", dv0);
        release_map("gap");

        // Reset after 1000 accepts, then a fresh frame.
        drive_frame(1000, 1, 0, -1);
        check("pre_rst_cnt", 32'(pixel_count), 32'd1000);
        do_reset("mid");
        dv0 = dv_cnt;
        drive_frame(TOTAL, 2, 0, TOTAL - 1);
        finish_frame("c", dv0);
        release_map("c_rel");

`ifdef FEATURE_LOADER_FRAME_CHECK_EN
        // Early s_last on pixel 99 discards the frame.
        dv0 = dv_cnt;
        drive_frame(100, 1, 0, 99);
        check("early_fe",    32'(frame_error), 32'd1);
        check("early_cnt",   32'(pixel_count), 32'd0);
        check("early_state", 32'(o_dbg_state), 32'(S_LOAD));
        repeat (3) @(negedge clk);
        check("early_no_dv", 32'(dv_cnt - dv0), 32'd0);
        dv0 = dv_cnt;
        drive_frame(TOTAL, 0, 0, TOTAL - 1);
        finish_frame("d", dv0);
        check("d_fe_sticky", 32'(frame_error), 32'd1);
        release_map("d_rel");
`endif

        // Missing s_last: frame still delivered; flag depends on build.
        do_reset("pre_miss");
        dv0 = dv_cnt;
        drive_frame(TOTAL, 3, 0, -1);
        finish_frame("e", dv0);
        check("miss_fe", 32'(frame_error), 32'(MISS_FE_EXP));
        release_map("e_rel");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
